// File: rtl/oldland_mem_arbiter.sv
// Oldland memory arbiter: shares one memory bus between the fetch and data ports.
module oldland_mem_arbiter #(
    parameter int unsigned MAX_D_GRANTS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_access,
    input  logic [31:0] i_addr,
    output logic [31:0] i_data,
    output logic        i_ack,
    input  logic        d_access,
    input  logic        d_wr_en,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wr_val,
    input  logic [3:0]  d_bytesel,
    output logic [31:0] d_data,
    output logic        d_ack,
    output logic        m_access,
    output logic [31:0] m_addr,
    output logic        m_wr_en,
    output logic [31:0] m_wr_val,
    output logic [3:0]  m_bytesel,
    input  logic [31:0] m_data,
    input  logic        m_ack
);

    localparam int unsigned STREAK_W = 3;
    localparam logic [STREAK_W-1:0] STREAK_MAX = '1;
    localparam logic [STREAK_W-1:0] D_LIMIT = STREAK_W'(MAX_D_GRANTS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [STREAK_W-1:0] d_streak, d_streak_nxt;
    logic                m_access_nxt, m_wr_en_nxt, i_ack_nxt, d_ack_nxt;
    logic [31:0]         m_addr_nxt, m_wr_val_nxt, i_data_nxt, d_data_nxt;
    logic [3:0]          m_bytesel_nxt;
    logic                turnaround, i_elig, d_elig, starve;

    // A port is not eligible while its own ack is showing; the ack cycle
    // itself is a turnaround with no grant, so a stale request is never re-served.
    assign turnaround = i_ack | d_ack;
    assign i_elig     = i_access & ~i_ack;
    assign d_elig     = d_access & ~d_ack;
    assign starve     = (d_streak >= D_LIMIT) & i_elig;

    // Next-state, grant and completion logic.
    always_comb begin
        state_nxt     = state;
        d_streak_nxt  = d_streak;
        m_access_nxt  = m_access;
        m_addr_nxt    = m_addr;
        m_wr_en_nxt   = m_wr_en;
        m_wr_val_nxt  = m_wr_val;
        m_bytesel_nxt = m_bytesel;
        i_ack_nxt     = 1'b0;
        d_ack_nxt     = 1'b0;
        i_data_nxt    = i_data;
        d_data_nxt    = d_data;

        unique case (state)
            IDLE: begin
                if (!turnaround && d_elig && !starve) begin
                    state_nxt     = D_BUSY;
                    m_access_nxt  = 1'b1;
                    m_addr_nxt    = d_addr;
                    m_wr_en_nxt   = d_wr_en;
                    m_wr_val_nxt  = d_wr_val;
                    m_bytesel_nxt = d_bytesel;
                    if (i_access) begin
                        d_streak_nxt = (d_streak == STREAK_MAX) ? d_streak
                                                                : d_streak + STREAK_W'(1);
                    end else begin
                        d_streak_nxt = '0;
                    end
                end else if (!turnaround && i_elig) begin
                    state_nxt     = I_BUSY;
                    m_access_nxt  = 1'b1;
                    m_addr_nxt    = i_addr;
                    m_wr_en_nxt   = 1'b0;
                    m_wr_val_nxt  = 32'h0;
                    m_bytesel_nxt = 4'hf;
                    d_streak_nxt  = '0;
                end else if (!i_access) begin
                    d_streak_nxt = '0;
                end
            end
            I_BUSY: begin
                if (m_ack) begin
                    state_nxt    = IDLE;
                    m_access_nxt = 1'b0;
                    i_ack_nxt    = 1'b1;
                    i_data_nxt   = m_data;
                end
            end
            D_BUSY: begin
                if (m_ack) begin
                    state_nxt    = IDLE;
                    m_access_nxt = 1'b0;
                    d_ack_nxt    = 1'b1;
                    d_data_nxt   = m_data;
                end
            end
            default: begin
                state_nxt    = IDLE;
                m_access_nxt = 1'b0;
            end
        endcase
    end

    // State, streak counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            d_streak  <= '0;
            m_access  <= 1'b0;
            m_addr    <= 32'h0;
            m_wr_en   <= 1'b0;
            m_wr_val  <= 32'h0;
            m_bytesel <= 4'h0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_data    <= 32'h0;
            d_data    <= 32'h0;
        end else begin
            state     <= state_nxt;
            d_streak  <= d_streak_nxt;
            m_access  <= m_access_nxt;
            m_addr    <= m_addr_nxt;
            m_wr_en   <= m_wr_en_nxt;
            m_wr_val  <= m_wr_val_nxt;
            m_bytesel <= m_bytesel_nxt;
            i_ack     <= i_ack_nxt;
            d_ack     <= d_ack_nxt;
            i_data    <= i_data_nxt;
            d_data    <= d_data_nxt;
        end
    end

endmodule

// File: tb/tb_oldland_mem_arbiter.sv
// Bench for oldland_mem_arbiter: transaction-level model, bus responder, directed and random traffic.
module tb_oldland_mem_arbiter;

    localparam int  MAXD  = 4;
    localparam int  NRAND = 1000;
    localparam byte GD    = 8'd68;
    localparam byte GI    = 8'd73;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_access = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] i_data;
    logic        i_ack;
    logic        d_access = 1'b0;
    logic        d_wr_en = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wr_val = 32'h0;
    logic [3:0]  d_bytesel = 4'h0;
    logic [31:0] d_data;
    logic        d_ack;
    logic        m_access;
    logic [31:0] m_addr;
    logic        m_wr_en;
    logic [31:0] m_wr_val;
    logic [3:0]  m_bytesel;
    logic [31:0] m_data = 32'h0;
    logic        m_ack = 1'b0;

    always #5 clk = ~clk;

    oldland_mem_arbiter #(.MAX_D_GRANTS(MAXD)) dut (
        .clk(clk), .rst(rst),
        .i_access(i_access), .i_addr(i_addr), .i_data(i_data), .i_ack(i_ack),
        .d_access(d_access), .d_wr_en(d_wr_en), .d_addr(d_addr), .d_wr_val(d_wr_val),
        .d_bytesel(d_bytesel), .d_data(d_data), .d_ack(d_ack),
        .m_access(m_access), .m_addr(m_addr), .m_wr_en(m_wr_en), .m_wr_val(m_wr_val),
        .m_bytesel(m_bytesel), .m_data(m_data), .m_ack(m_ack)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int          own = 0;     // 0 bus free, 1 fetch owns bus, 2 data owns bus
    int          streak = 0;
    logic        e_macc = 1'b0, e_mwe = 1'b0, e_iack = 1'b0, e_dack = 1'b0;
    logic [31:0] e_maddr = 32'h0, e_mwv = 32'h0, e_idata = 32'h0, e_ddata = 32'h0;
    logic [3:0]  e_mbs = 4'h0;
    byte         glog[$];

    task automatic model_step();
        bit turn;
        if (rst) begin
            own = 0; streak = 0;
            e_macc = 0; e_mwe = 0; e_iack = 0; e_dack = 0;
            e_maddr = 0; e_mwv = 0; e_idata = 0; e_ddata = 0; e_mbs = 0;
        end else if (own != 0) begin
            if (m_ack) begin
                e_macc = 0;
                if (own == 1) begin e_iack = 1; e_idata = m_data; end
                else          begin e_dack = 1; e_ddata = m_data; end
                own = 0;
            end
        end else begin
            turn = e_iack || e_dack;
            e_iack = 0; e_dack = 0;
            if (!turn && d_access && !(streak >= MAXD && i_access)) begin
                own = 2; e_macc = 1; e_maddr = d_addr; e_mwe = d_wr_en;
                e_mwv = d_wr_val; e_mbs = d_bytesel;
                streak = i_access ? ((streak < 7) ? streak + 1 : 7) : 0;
                glog.push_back(GD);
            end else if (!turn && i_access) begin
                own = 1; e_macc = 1; e_maddr = i_addr; e_mwe = 0; e_mwv = 0; e_mbs = 4'hf;
                streak = 0;
                glog.push_back(GI);
            end else if (!i_access) begin
                streak = 0;
            end
        end
    endtask

    task automatic compare();
        chk("m_access", 32'(m_access), 32'(e_macc));
        chk("m_addr", m_addr, e_maddr);
        chk("m_wr_en", 32'(m_wr_en), 32'(e_mwe));
        chk("m_wr_val", m_wr_val, e_mwv);
        chk("m_bytesel", 32'(m_bytesel), 32'(e_mbs));
        chk("i_ack", 32'(i_ack), 32'(e_iack));
        chk("d_ack", 32'(d_ack), 32'(e_dack));
        chk("i_data", i_data, e_idata);
        chk("d_data", d_data, e_ddata);
        chk("acks_exclusive", 32'(i_ack & d_ack), 32'h0);
        chk("ack_with_m_access", 32'((i_ack | d_ack) & m_access), 32'h0);
    endtask

    // Model advances on the rising edge, outputs compared on the falling edge.
    always begin
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    end

    // ---------------- requesters and bus responder ----------------
    logic [31:0] mem [256];
    int          mode = 0;         // 0 manual, 1 continuous, 2 random
    bit          resp_en = 1'b1;
    bit          bus_active = 1'b0;
    int          lat_cnt = 0;
    int          fixed_lat = 0;
    bit          wr_resp_rand = 1'b0;
    logic [31:0] last_wresp = 32'h0;
    bit          i_pend = 1'b0, d_pend = 1'b0;
    int          issued_total = 0, acked_total = 0, issue_limit = 0;
    int          i_ack_seen = 0, d_ack_seen = 0;

    function automatic logic [31:0] rand_addr();
        return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    task automatic issue_i(input logic [31:0] a);
        i_access = 1'b1; i_addr = a; i_pend = 1'b1; issued_total++;
    endtask

    task automatic issue_d(input logic we, input logic [31:0] a, input logic [31:0] v,
                           input logic [3:0] bs);
        d_access = 1'b1; d_wr_en = we; d_addr = a; d_wr_val = v; d_bytesel = bs;
        d_pend = 1'b1; issued_total++;
    endtask

    task automatic issue_d_rand();
        issue_d(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)));
    endtask

    task automatic cycle();
        logic [7:0]  idx;
        logic [31:0] wresp;
        @(posedge clk);
        #1;
        if (i_ack === 1'b1) begin
            i_ack_seen++;
            chk("i_ack_when_pending", 32'(i_pend), 32'h1);
            chk("i_data_vs_mem", i_data, mem[i_addr[9:2]]);
            acked_total++; i_pend = 1'b0; i_access = 1'b0;
        end
        if (d_ack === 1'b1) begin
            d_ack_seen++;
            chk("d_ack_when_pending", 32'(d_pend), 32'h1);
            chk("d_data_vs_mem", d_data, d_wr_en ? last_wresp : mem[d_addr[9:2]]);
            acked_total++; d_pend = 1'b0; d_access = 1'b0;
        end
        if (m_ack) begin
            m_ack = 1'b0;
        end else if (resp_en && m_access) begin
            if (!bus_active) begin
                bus_active = 1'b1;
                lat_cnt = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 16));
            end else begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    idx = m_addr[9:2];
                    m_ack = 1'b1;
                    if (m_wr_en) begin
                        wresp = wr_resp_rand ? $urandom : 32'h5A5A_5A5A;
                        last_wresp = wresp;
                        m_data = wresp;
                        for (int b = 0; b < 4; b++)
                            if (m_bytesel[b]) mem[idx][8*b +: 8] = m_wr_val[8*b +: 8];
                    end else begin
                        m_data = mem[idx];
                    end
                    bus_active = 1'b0;
                end
            end
        end
        if (mode == 1) begin
            if (!i_pend) issue_i(rand_addr());
            if (!d_pend) issue_d_rand();
        end else if (mode == 2) begin
            if (!i_pend && issued_total < issue_limit && $urandom_range(0, 2) == 0)
                issue_i(rand_addr());
            if (!d_pend && issued_total < issue_limit && $urandom_range(0, 2) == 0)
                issue_d_rand();
        end
    endtask

    // sel: 0 m_access, 1 i_ack, 2 d_ack, 3 both ports idle, 4 ten grants logged
    task automatic wait_until(input int sel, input int limit, input string name);
        int n;
        bit hit;
        n = 0; hit = 1'b0;
        while (!hit && n < limit) begin
            cycle();
            n++;
            case (sel)
                0: hit = (m_access === 1'b1);
                1: hit = (i_ack === 1'b1);
                2: hit = (d_ack === 1'b1);
                3: hit = !i_pend && !d_pend;
                default: hit = (glog.size() >= 10);
            endcase
        end
        chk(name, 32'(hit), 32'h1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        string exp_order;
        int base, base_a, n;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        // Reset
        cycle();
        cycle();
        chk("rst_m_access", 32'(m_access), 32'h0);
        chk("rst_m_bytesel", 32'(m_bytesel), 32'h0);
        chk("rst_i_data", i_data, 32'h0);
        rst = 1'b0;
        cycle();

        // Single fetch with a two-cycle bus
        mem[8'h40] = 32'hCAFE_0001;
        fixed_lat = 2;
        base = i_ack_seen;
        issue_i(32'h100);
        wait_until(0, 20, "r16_grant_timeout");
        chk("r16_m_addr", m_addr, 32'h100);
        chk("r16_m_wr_en", 32'(m_wr_en), 32'h0);
        wait_until(1, 40, "r16_ack_timeout");
        chk("r16_i_data", i_data, 32'hCAFE_0001);
        for (int k = 0; k < 3; k++) cycle();
        chk("r16_ack_count", 32'(i_ack_seen - base), 32'h1);

        // Simultaneous requests: data wins, fetch follows
        glog.delete();
        mem[8'h80] = 32'h0BAD_0200;
        fixed_lat = 1;
        issue_i(32'h200);
        issue_d(1'b1, 32'h80, 32'h1234_5678, 4'h3);
        wait_until(0, 20, "r17_grant_timeout");
        chk("r17_m_addr", m_addr, 32'h80);
        chk("r17_m_wr_en", 32'(m_wr_en), 32'h1);
        chk("r17_m_wr_val", m_wr_val, 32'h1234_5678);
        chk("r17_m_bytesel", 32'(m_bytesel), 32'h3);
        wait_until(2, 40, "r17_d_ack_timeout");
        wait_until(1, 40, "r17_i_ack_timeout");
        chk("r17_i_data", i_data, 32'h0BAD_0200);
        chk("r17_d_data", d_data, 32'h5A5A_5A5A);
        chk("r17_grant_count", 32'(glog.size()), 32'h2);
        chk("r17_first_grant", 32'(glog[0]), 32'(GD));
        chk("r17_second_grant", 32'(glog[1]), 32'(GI));

        // Spurious bus ack while idle
        for (int k = 0; k < 3; k++) cycle();
        m_ack = 1'b1;
        m_data = 32'hFFFF_FFFF;
        cycle();
        chk("r20_i_ack", 32'(i_ack), 32'h0);
        chk("r20_d_ack", 32'(d_ack), 32'h0);
        cycle();
        chk("r20_i_ack_late", 32'(i_ack), 32'h0);
        chk("r20_d_ack_late", 32'(d_ack), 32'h0);
        chk("r20_i_data", i_data, 32'h0BAD_0200);
        chk("r20_d_data", d_data, 32'h5A5A_5A5A);

        // Starvation limit with both ports always requesting
        glog.delete();
        fixed_lat = 0;
        mode = 1;
        wait_until(4, 2000, "r18_grants_timeout");
        mode = 0;
        wait_until(3, 200, "r18_drain_timeout");
        exp_order = "DDDDIDDDDI";
        for (int k = 0; k < 10; k++)
            chk($sformatf("r18_grant%0d", k), 32'(glog[k]), 32'(exp_order[k]));

        // Reset in the middle of a data access, then a late bus ack
        resp_en = 1'b0;
        issue_d(1'b0, 32'h40, 32'h0, 4'hf);
        wait_until(0, 20, "r19_grant_timeout");
        base = d_ack_seen;
        rst = 1'b1;
        d_access = 1'b0;
        d_pend = 1'b0;
        cycle();
        chk("r19_m_access_after_rst", 32'(m_access), 32'h0);
        chk("r19_d_data_after_rst", d_data, 32'h0);
        rst = 1'b0;
        bus_active = 1'b0;
        cycle();
        m_ack = 1'b1;
        m_data = 32'hFFFF_FFFF;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("r19_d_ack", 32'(d_ack), 32'h0);
            chk("r19_d_data", d_data, 32'h0);
        end
        chk("r19_d_ack_count", 32'(d_ack_seen - base), 32'h0);
        resp_en = 1'b1;

        // Random mixed traffic with random bus latency
        wr_resp_rand = 1'b1;
        base_a = acked_total;
        issue_limit = issued_total + NRAND;
        mode = 2;
        n = 0;
        while (!(issued_total >= issue_limit && !i_pend && !d_pend) && n < 60000) begin
            cycle();
            n++;
        end
        mode = 0;
        chk("rand_finished", 32'(n < 60000), 32'h1);
        chk("rand_acked", 32'(acked_total - base_a), 32'(NRAND));
        for (int k = 0; k < 4; k++) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
